regheap_drain_64x16b: RTL and testbench

Read-out engine for the 64×16-bit self-adding register heap. When accumulation finishes, it snapshots the heap's 1024-bit result vector and clears the heap for the next accumulation round. It then streams the snapshot downstream as 256-bit beats over a valid/ready handshake. It sits between the heap's output bus and the write-back/packing stage.

---
 rtl/regheap_drain_64x16b.sv | 53 +++++
 tb/tb_regheap_drain_64x16b.sv | 155 +++++++++++++++
 2 files changed

// File: rtl/regheap_drain_64x16b.sv
// regheap_drain_64x16b: snapshots the 64x16b heap on acc_done, clears it, and streams the result as four 256-bit beats
module regheap_drain_64x16b #(
  parameter int LANES = 64,
  parameter int WORD_W = 16,
  parameter int BEAT_WORDS = 16
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      acc_done,
  input  logic [LANES*WORD_W-1:0]   heap_data,
  output logic                      heap_clr,
  output logic [BEAT_WORDS*WORD_W-1:0] out_data,
  output logic                      out_v,
  input  logic                      out_ready,
  output logic                      out_last,
  output logic                      busy,
  output logic                      overrun
);
  localparam int BEATS = LANES / BEAT_WORDS;
  localparam int OUT_W = BEAT_WORDS * WORD_W;
  localparam int CNT_W = $clog2(BEATS);
  typedef enum logic {IDLE, SEND} state_t;
  state_t state, state_n;
  logic [LANES*WORD_W-1:0] snapshot;
  logic [CNT_W-1:0] beat_cnt;
  logic take, fire;
  assign take = (state == IDLE) && acc_done;
  assign fire = out_v && out_ready;
  assign out_v = state == SEND;
  assign busy = state == SEND;
  assign out_last = out_v && (beat_cnt == CNT_W'(BEATS - 1));
  assign out_data = snapshot[int'(beat_cnt) * OUT_W +: OUT_W];
  always_comb begin
    state_n = state;
    state_n = (state == IDLE) ? (acc_done ? SEND : IDLE) : ((fire && out_last) ? IDLE : SEND);
  end
  // acc_done seen in SEND (including the final-beat cycle) is dropped and flagged
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      snapshot <= '0;
      beat_cnt <= '0;
      heap_clr <= 1'b0;
      overrun <= 1'b0;
    end else begin
      state <= state_n;
      heap_clr <= take;
      overrun <= busy && acc_done;
      if (take) snapshot <= heap_data;
      beat_cnt <= (state == IDLE) ? '0 : fire ? beat_cnt + 1'b1 : beat_cnt;
    end
  end
endmodule

// File: tb/tb_regheap_drain_64x16b.sv
// tb_regheap_drain_64x16b: per-cycle directed vectors plus an async-reset sequence
module tb_regheap_drain_64x16b;
  logic clk = 0, rst = 1, acc_done = 0, out_ready = 0;
  logic [1023:0] heap_data = '0;
  logic heap_clr, out_v, out_last, busy, overrun;
  logic [255:0] out_data;
  int checks = 0, errors = 0;

  regheap_drain_64x16b dut (
    .clk(clk), .rst(rst), .acc_done(acc_done), .heap_data(heap_data),
    .heap_clr(heap_clr), .out_data(out_data), .out_v(out_v), .out_ready(out_ready),
    .out_last(out_last), .busy(busy), .overrun(overrun)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic acc, rdy;
    int hp;
    logic ev, el, ec, eo;
    int eb, ep;
  } vec_t;
  vec_t q[$];

  function automatic logic [1023:0] mk(int p);
    logic [1023:0] s;
    for (int i = 0; i < 64; i++)
      s[16*i +: 16] = (p == 0) ? 16'(i + 1) : (p == 1) ? 16'hFFFF : ((i % 2) ? 16'hFFFF : 16'h0000);
    if (p == 2) s[1023:1008] = 16'h8000;
    return s;
  endfunction

  function automatic logic [255:0] beat(int p, int b);
    logic [1023:0] s;
    s = mk(p);
    return s[256*b +: 256];
  endfunction

  task automatic chk(string name, logic [255:0] act, logic [255:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s @%0t: got %h expected %h", name, $time, act, exp);
    end
  endtask

  task automatic row(logic acc, logic rdy, int hp, logic ev, logic el, logic ec, logic eo, int eb, int ep);
    q.push_back('{acc, rdy, hp, ev, el, ec, eo, eb, ep});
  endtask

  task automatic chk_idle(string tag);
    chk({tag, "_v"}, 256'(out_v), 256'(0));
    chk({tag, "_busy"}, 256'(busy), 256'(0));
    chk({tag, "_last"}, 256'(out_last), 256'(0));
    chk({tag, "_clr"}, 256'(heap_clr), 256'(0));
  endtask

  initial begin
    // lanes i+1, ready high
    row(1,1,0, 0,0,0,0, 0,0);
    row(0,1,0, 1,0,1,0, 0,0);
    row(0,1,0, 1,0,0,0, 1,0);
    row(0,1,0, 1,0,0,0, 2,0);
    row(0,1,0, 1,1,0,0, 3,0);
    row(0,1,0, 0,0,0,0, 0,0);
    // ready pattern 1,0,0,1,0,1,1
    row(1,1,0, 0,0,0,0, 0,0);
    row(0,1,0, 1,0,1,0, 0,0);
    row(0,0,0, 1,0,0,0, 1,0);
    row(0,0,0, 1,0,0,0, 1,0);
    row(0,1,0, 1,0,0,0, 1,0);
    row(0,0,0, 1,0,0,0, 2,0);
    row(0,1,0, 1,0,0,0, 2,0);
    row(0,1,0, 1,1,0,0, 3,0);
    row(0,1,0, 0,0,0,0, 0,0);
    // acc_done during beat1 with heap all 0xFFFF
    row(1,1,0, 0,0,0,0, 0,0);
    row(0,1,0, 1,0,1,0, 0,0);
    row(1,1,1, 1,0,0,0, 1,0);
    row(0,1,1, 1,0,0,1, 2,0);
    row(0,1,1, 1,1,0,0, 3,0);
    row(0,1,0, 0,0,0,0, 0,0);
    // acc_done on the final-beat transfer, then a fresh one with boundary pattern
    row(1,1,0, 0,0,0,0, 0,0);
    row(0,1,0, 1,0,1,0, 0,0);
    row(0,1,0, 1,0,0,0, 1,0);
    row(0,1,0, 1,0,0,0, 2,0);
    row(1,1,1, 1,1,0,0, 3,0);
    row(1,1,2, 0,0,0,1, 0,0);
    row(0,1,0, 1,0,1,0, 0,2);
    row(0,1,0, 1,0,0,0, 1,2);
    row(0,1,0, 1,0,0,0, 2,2);
    row(0,1,0, 1,1,0,0, 3,2);
    row(0,1,0, 0,0,0,0, 0,0);

    repeat (2) @(posedge clk);
    @(negedge clk);
    chk_idle("rst");
    chk("rst_ovr", 256'(overrun), 256'(0));
    chk("rst_data", out_data, 256'(0));
    rst = 0;

    for (int i = 0; i < q.size(); i++) begin
      @(negedge clk);
      acc_done = q[i].acc;
      out_ready = q[i].rdy;
      heap_data = mk(q[i].hp);
      #1;
      chk($sformatf("v%0d", i), 256'(out_v), 256'(q[i].ev));
      chk($sformatf("busy%0d", i), 256'(busy), 256'(q[i].ev));
      chk($sformatf("last%0d", i), 256'(out_last), 256'(q[i].el));
      chk($sformatf("clr%0d", i), 256'(heap_clr), 256'(q[i].ec));
      chk($sformatf("ovr%0d", i), 256'(overrun), 256'(q[i].eo));
      if (q[i].ev) chk($sformatf("data%0d", i), out_data, beat(q[i].ep, q[i].eb));
    end

    // async reset while stalled on beat2
    @(negedge clk);
    acc_done = 1; out_ready = 1; heap_data = mk(0);
    @(negedge clk);
    acc_done = 0;
    @(negedge clk);
    @(negedge clk);
    out_ready = 0;
    #1;
    chk("pre_rst_v", 256'(out_v), 256'(1));
    chk("pre_rst_data", out_data, beat(0, 2));
    #2 rst = 1;
    #1;
    chk_idle("arst");
    chk("arst_data", out_data, 256'(0));
    @(negedge clk);
    rst = 0;
    out_ready = 1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      #1;
      chk_idle($sformatf("post%0d", i));
    end
    @(negedge clk);
    acc_done = 1; heap_data = mk(2);
    @(negedge clk);
    acc_done = 0; heap_data = '0;
    #1;
    chk("restart_v", 256'(out_v), 256'(1));
    chk("restart_clr", 256'(heap_clr), 256'(1));
    chk("restart_data", out_data, beat(2, 0));
    repeat (4) @(negedge clk);
    #1;
    chk_idle("end");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
